// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the two-input gate sweep checker.
// Latency: none (types, constants and an elaboration-time helper only).
// Backpressure: none.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // Expected gate output, indexed by {a,b}
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NOR  = 4'b0001;

    // Bits needed to hold values 0..n-1, never less than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gate_chk_timer.sv
// Loadable down-counter that flags the last settle cycle.
// Latency: expire_o is high in the cycle where the count equals 1.
// Backpressure: none; counts down every cycle until it reaches zero.
module gate_chk_timer
    import gate_chk_pkg::*;
#(
    parameter int unsigned LOAD_VAL = 2,
    parameter int unsigned W        = cnt_width(LOAD_VAL + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over counting; the counter parks at zero once it runs out
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(LOAD_VAL);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive {a,b} sweeper for a 2-in gate; checks c against a truth table.
// Latency: done pulses PASSES*4*(SETTLE_CYCLES+2)+1 cycles after start.
// Backpressure: none; start is ignored unless the sequencer is idle.
module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  TRUTH_TT      = TT_NAND,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             a_o,
    output logic             b_o,
    input  logic             c_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [3:0]       fail_vec_o
);

    localparam int unsigned   PW        = cnt_width(PASSES);
    localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [PW-1:0]    pidx_q, pidx_d;
    logic [1:0]       ab_q, ab_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fv_q, fv_d;
    logic             pass_q, pass_d;
    logic             timer_load;
    logic             timer_expire;
    logic             mismatch;

    gate_chk_timer #(
        .LOAD_VAL (SETTLE_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (timer_load),
        .expire_o (timer_expire)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one vector per APPLY..SAMPLE slot, DONE after the last pass
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start_i) state_d = APPLY;
            APPLY:  state_d = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
            SETTLE: if (timer_expire) state_d = SAMPLE;
            SAMPLE: begin
                if (vec_q != 2'd3 || pidx_q < LAST_PASS) begin
                    state_d = APPLY;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy_o     = (state_q == APPLY) || (state_q == SETTLE) || (state_q == SAMPLE);
        done_o     = (state_q == DONE);
        timer_load = (state_q == APPLY);
    end

    // Vector/pass sequencing, compare and saturating error count
    always_comb begin
        vec_d    = vec_q;
        pidx_d   = pidx_q;
        ab_d     = ab_q;
        err_d    = err_q;
        fv_d     = fv_q;
        pass_d   = pass_q;
        mismatch = (state_q == SAMPLE) && (c_i != TRUTH_TT[vec_q]);

        if (state_q == IDLE && start_i) begin
            vec_d  = 2'd0;
            pidx_d = '0;
            err_d  = '0;
            fv_d   = 4'b0000;
            pass_d = 1'b0;
        end

        if (state_q == SAMPLE) begin
            if (mismatch) begin
                if (err_q != '1) begin
                    err_d = err_q + ERR_W'(1);
                end
                fv_d[vec_q] = 1'b1;
            end
            if (vec_q != 2'd3) begin
                vec_d = vec_q + 2'd1;
            end else if (pidx_q < LAST_PASS) begin
                pidx_d = pidx_q + PW'(1);
                vec_d  = 2'd0;
            end
        end

        // pass is registered on entry to DONE so it is valid alongside done
        if (state_q == SAMPLE && state_d == DONE) begin
            pass_d = (err_d == '0);
        end

        // The gate inputs change only on entry to APPLY and hold otherwise
        if (state_d == APPLY) begin
            ab_d = vec_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vec_q  <= 2'd0;
            pidx_q <= '0;
            ab_q   <= 2'd0;
            err_q  <= '0;
            fv_q   <= 4'b0000;
            pass_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            pidx_q <= pidx_d;
            ab_q   <= ab_d;
            err_q  <= err_d;
            fv_q   <= fv_d;
            pass_q <= pass_d;
        end
    end

    assign a_o         = ab_q[1];
    assign b_o         = ab_q[0];
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_vec_o  = fv_q;

endmodule
